// File: rtl/mul4_seq_if.sv
// Start/done handshake bundle for the sequential 4x4 multiplier.
// The requester drives operands and start; the multiplier returns product and status.
interface mul4_seq_if;
    logic       start;
    logic [3:0] A;
    logic [3:0] B;
    logic [7:0] P;
    logic       busy;
    logic       done;

    modport master (output start, A, B, input P, busy, done);
    modport slave  (input start, A, B, output P, busy, done);
endinterface

// File: rtl/mul4_seq.sv
// Sequential 4x4 unsigned shift-and-add multiplier built on the 4-bit ripple adder sum4.
// One add-and-shift step per clock, four steps per product, start/done handshake.
module sum4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c_in,
    output logic [3:0] s,
    output logic       c_out
);
    logic [4:0] carry;

    always_comb begin
        carry    = '0;
        s        = '0;
        carry[0] = c_in;
        for (int i = 0; i < 4; i++) begin
            s[i]       = a[i] ^ b[i] ^ carry[i];
            carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
        c_out = carry[4];
    end
endmodule

module mul4_seq (
    input  logic       clk,
    input  logic       reset,
    mul4_seq_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state;
    state_t     next_state;
    logic [3:0] m;
    logic [3:0] acc;
    logic [3:0] q;
    logic [1:0] cnt;
    logic [7:0] p;
    logic [3:0] addend;
    logic [3:0] sum;
    logic       carry_out;
    logic [7:0] shifted;
    logic       busy;
    logic       done;

    assign addend  = q[0] ? m : 4'h0;
    // Carry out lands in ACC[3] so no partial-product bit is ever lost.
    assign shifted = {carry_out, sum, q[3:1]};

    sum4 adder (
        .a     (acc),
        .b     (addend),
        .c_in  (1'b0),
        .s     (sum),
        .c_out (carry_out)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (cnt == 2'd3) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // P only changes on the last iteration, so it shows the previous product during a run.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m   <= 4'h0;
            acc <= 4'h0;
            q   <= 4'h0;
            cnt <= 2'd0;
            p   <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        m   <= bus.A;
                        q   <= bus.B;
                        acc <= 4'h0;
                        cnt <= 2'd0;
                    end
                end
                RUN: begin
                    acc <= shifted[7:4];
                    q   <= shifted[3:0];
                    cnt <= cnt + 2'd1;
                    if (cnt == 2'd3) begin
                        p <= shifted;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.P    = p;
    assign bus.busy = busy;
    assign bus.done = done;
endmodule

// File: tb/tb_mul4_seq.sv
// Self-checking bench for mul4_seq: products come from plain A*B arithmetic and
// the handshake timing from the documented accept-to-done latency.
module tb_mul4_seq;
    logic       clk;
    logic       reset;
    int         total = 0;
    int         bad   = 0;
    logic [7:0] model_p = 8'h00;

    mul4_seq_if bus ();

    mul4_seq dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic test_reset();
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.A     = 4'h0;
        bus.B     = 4'h0;
        #1;
        total++;
        if (bus.P !== 8'h00) begin bad++; $display("[TB] FAIL reset_p got=%0h want=0", bus.P); end
        total++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            bad++; $display("[TB] FAIL reset_status got busy=%0b done=%0b want 0/0", bus.busy, bus.done);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        total++;
        if (bus.P !== 8'h00 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            bad++; $display("[TB] FAIL post_reset_idle got P=%0h busy=%0b done=%0b", bus.P, bus.busy, bus.done);
        end
    endtask

    // One operation: expects 4 busy cycles, done exactly 4 cycles after accept, P held until then.
    task automatic run_op(input logic [3:0] a, input logic [3:0] b, input bit hold_start);
        logic [7:0] want;
        int         busy_cnt;
        int         done_cnt;
        int         done_at;
        want     = 8'(a) * 8'(b);
        busy_cnt = 0;
        done_cnt = 0;
        done_at  = -1;
        @(negedge clk);
        bus.A     = a;
        bus.B     = b;
        bus.start = 1'b1;
        @(negedge clk);
        if (!hold_start) bus.start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            bus.A = 4'($urandom);
            bus.B = 4'($urandom);
            if (hold_start && i == 5) bus.start = 1'b0;
            if (bus.busy === 1'b1) busy_cnt++;
            if (bus.done === 1'b1) begin
                done_cnt++;
                done_at = i;
                total++;
                if (bus.P !== want) begin
                    bad++; $display("[TB] FAIL product %0d*%0d got=%0h want=%0h", a, b, bus.P, want);
                end
            end else if (done_at < 0) begin
                total++;
                if (bus.P !== model_p) begin
                    bad++; $display("[TB] FAIL p_held %0d*%0d got=%0h want=%0h", a, b, bus.P, model_p);
                end
            end
            @(negedge clk);
        end
        total++;
        if (busy_cnt != 4) begin bad++; $display("[TB] FAIL busy_cycles %0d*%0d got=%0d want=4", a, b, busy_cnt); end
        total++;
        if (done_cnt != 1) begin bad++; $display("[TB] FAIL done_count %0d*%0d got=%0d want=1", a, b, done_cnt); end
        total++;
        if (done_at != 4) begin bad++; $display("[TB] FAIL done_latency %0d*%0d got=%0d want=4", a, b, done_at); end
        total++;
        if (bus.P !== want) begin bad++; $display("[TB] FAIL p_after %0d*%0d got=%0h want=%0h", a, b, bus.P, want); end
        bus.start = 1'b0;
        model_p   = want;
    endtask

    task automatic test_basic();
        run_op(4'd3, 4'd5, 1'b0);
    endtask

    task automatic test_max();
        run_op(4'd15, 4'd15, 1'b0);
    endtask

    task automatic test_zero();
        run_op(4'd0, 4'd9, 1'b0);
        run_op(4'd9, 4'd0, 1'b0);
    endtask

    task automatic test_random();
        for (int k = 0; k < 6; k++) begin
            run_op(4'($urandom), 4'($urandom), 1'b0);
        end
    endtask

    task automatic test_ignored_start();
        run_op(4'd11, 4'd13, 1'b1);
        run_op(4'd6, 4'd7, 1'b1);
    endtask

    // All 256 pairs with start held high: accepts every 6 clocks, results checked in order.
    task automatic test_back_to_back();
        logic [7:0] pending[$];
        logic [7:0] want;
        int         last_done;
        int         dones;
        last_done = -1;
        dones     = 0;
        pending.delete();
        for (int n = 0; n < 1545; n++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                dones++;
                total++;
                if (pending.size() == 0) begin
                    bad++; $display("[TB] FAIL sweep_extra_done at n=%0d", n);
                end else begin
                    want = pending.pop_front();
                    if (bus.P !== want) begin
                        bad++; $display("[TB] FAIL sweep_product n=%0d got=%0h want=%0h", n, bus.P, want);
                    end
                end
                total++;
                if ((last_done < 0 && n != 5) || (last_done >= 0 && n - last_done != 6)) begin
                    bad++; $display("[TB] FAIL sweep_spacing n=%0d prev=%0d want gap 6", n, last_done);
                end
                last_done = n;
            end
            if (n < 1536) begin
                bus.start = 1'b1;
                if (n % 6 == 0) begin
                    bus.A = 4'(n / 6 / 16);
                    bus.B = 4'(n / 6 % 16);
                    pending.push_back(8'(bus.A) * 8'(bus.B));
                end else begin
                    bus.A = 4'($urandom);
                    bus.B = 4'($urandom);
                end
            end else begin
                bus.start = 1'b0;
            end
        end
        total++;
        if (dones != 256) begin bad++; $display("[TB] FAIL sweep_done_total got=%0d want=256", dones); end
        model_p = 8'd225;
    endtask

    task automatic test_async_reset();
        run_op(4'd7, 4'd6, 1'b0);
        total++;
        if (bus.P !== 8'h2A) begin bad++; $display("[TB] FAIL p_7x6 got=%0h want=2a", bus.P); end
        @(negedge clk);
        bus.A     = 4'd2;
        bus.B     = 4'd2;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        total++;
        if (bus.P !== 8'h00 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            bad++; $display("[TB] FAIL async_reset got P=%0h busy=%0b done=%0b want 0/0/0", bus.P, bus.busy, bus.done);
        end
        @(negedge clk);
        @(negedge clk);
        reset   = 1'b0;
        model_p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            total++;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.P !== 8'h00) begin
                bad++; $display("[TB] FAIL aborted_quiet i=%0d got P=%0h busy=%0b done=%0b", i, bus.P, bus.busy, bus.done);
            end
        end
        run_op(4'd2, 4'd2, 1'b0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_max();
        test_zero();
        test_random();
        test_ignored_start();
        test_back_to_back();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mul4_seq.md
# mul4_seq

Sequential 4x4 unsigned shift-and-add multiplier built around a single instance of the team's 4-bit ripple adder `sum4`, with `c_in` tied to 0. A small FSM sequences one add-and-shift step per clock and runs a start/done handshake. It produces an 8-bit product. It is the first sequenced consumer of the ALU adder and serves as the multiply path of the p01 ALU.

## Interface
- No parameters. Operand width is fixed at 4 bits and product width at 8 bits.
- `clk`  in  1  sole clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  request; sampled only in IDLE.
- `A`  in  4  multiplicand (unsigned), captured when start is accepted.
- `B`  in  4  multiplier (unsigned), captured when start is accepted.
- `P`  out  8  product register; reset 0x00.
- `busy`  out  1  high in RUN; reset 0.
- `done`  out  1  one-cycle completion pulse, high in DONE; reset 0.

## Operation
- Internal registers:
  - M[3:0]: multiplicand.
  - ACC[3:0]: high half of partial product.
  - Q[3:0]: multiplier / low half of partial product.
  - CNT[1:0]: iteration count.
  - state: IDLE, RUN, DONE.
- All registers reset to 0. State resets to IDLE.
- Adder connections: operand A = ACC, operand B = (Q[0] ? M : 4'h0), c_in = 0. This yields S[3:0] and c_out.
- IDLE:
  - busy=0, done=0.
  - If start=1 at the edge: M<=A, Q<=B, ACC<=0, CNT<=0, state<=RUN.
  - If start=0, nothing changes and P holds.
- RUN:
  - busy=1.
  - Each edge: {ACC,Q} <= {c_out, S, Q[3:1]}, i.e. the 9-bit value {c_out,S,Q} shifted right by 1. CNT<=CNT+1.
  - On the edge where CNT==3 (4th iteration): P<={new ACC,new Q}, state<=DONE.
- DONE:
  - done=1, busy=0 for exactly one cycle.
  - Next edge: state<=IDLE unconditionally.
- Arithmetic rules:
  - No overflow is possible; the 9-bit shift keeps c_out every step.
  - The 15x15 maximum of 225 fits in 8 bits.
- P is written only on the final RUN edge. P holds the last product through IDLE and through the whole next RUN, and is replaced only when that run completes.
- start is ignored in RUN and DONE: no restart and no queueing.
- Changes on A/B after acceptance have no effect on the running operation.
- reset asserted at any time, including mid-RUN or in DONE:
  - Immediately (asynchronously) forces IDLE.
  - Forces P=0, busy=0, done=0, and clears all internal registers.
  - The aborted operation produces no done pulse.

## Timing
- Let edge E0 be the edge where start=1 is sampled in IDLE.
- Edges E1..E4 perform iterations 1..4. busy=1 from after E0 until E4.
- After E4: done=1 and P is valid, in the same cycle. After E5: done=0, state is IDLE.
- Latency from the accepting edge to the done cycle is 4 clocks.
- Minimum start-to-start spacing is 6 clocks: the earliest next accept is E6, since start at E5 is sampled in DONE and ignored.
- Outputs are registered except busy and done, which decode state. No combinational path from inputs to outputs.
- The adder sits on the ACC->ACC path within one cycle: 4-bit ripple plus mux.

## Test plan
- Reset, then A=3, B=5, start pulsed one cycle:
  - busy high for 4 cycles.
  - done pulses once, in the cycle after the 4th iteration edge.
  - P=0x0F at that pulse and held afterwards.
- A=15, B=15 -> P=0xE1 (225). Checks that c_out is carried into ACC[3].
- A=0, B=9 and A=9, B=0 -> P=0x00. Timing must be identical: always 4 iterations.
- Exhaustive sweep of all 256 A/B pairs, back-to-back with start held high:
  - Each result equals A*B.
  - Each done is exactly 6 clocks after the previous one.
  - Mid-run A/B toggles do not corrupt results.
- Assert start again during RUN and during DONE -> ignored:
  - Exactly one done pulse per accepted start.
  - P is unchanged until that completion.
- Complete 7x6 (P=0x2A), start 2x2, and assert reset asynchronously (not on a clock edge) at iteration 2:
  - P, busy and done go to 0 immediately.
  - No done pulse follows.
  - A new 2x2 after reset release gives P=0x04.
